// File: rtl/axil_sram_pkg.sv
// rtl/axil_sram_pkg.sv - shared response codes and sizing helper for the AXI-Lite SRAM slave
package axil_sram_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Number of byte-offset address bits for a given data bus width.
    function automatic int byte_shift(input int data_width);
        int shift;
        shift = 0;
        while ((1 << shift) < (data_width / 8)) begin
            shift++;
        end
        return shift;
    endfunction

endpackage

// File: rtl/axil_sram_rfifo.sv
// rtl/axil_sram_rfifo.sv - two-entry {data, resp} queue holding read beats until R accepts them
module axil_sram_rfifo #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic [1:0]            push_resp_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] head_data_o,
    output logic [1:0]            head_resp_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [1:0]            count_o
);

    logic [DATA_WIDTH-1:0] data_q [2];
    logic [1:0]            resp_q [2];
    logic                  rd_ptr_q;
    logic                  wr_ptr_q;
    logic [1:0]            count_q;
    logic [1:0]            count_d;
    logic                  do_push;
    logic                  do_pop;

    assign do_push = push_i && (count_q != 2'd2);
    assign do_pop  = pop_i && (count_q != 2'd0);

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Storage is cleared on reset so the head reads as zero while empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
            data_q[0] <= '0;
            data_q[1] <= '0;
            resp_q[0] <= 2'b00;
            resp_q[1] <= 2'b00;
        end else begin
            count_q <= count_d;
            if (do_push) begin
                data_q[wr_ptr_q] <= push_data_i;
                resp_q[wr_ptr_q] <= push_resp_i;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    assign head_data_o = data_q[rd_ptr_q];
    assign head_resp_o = resp_q[rd_ptr_q];
    assign full_o      = (count_q == 2'd2);
    assign empty_o     = (count_q == 2'd0);
    assign count_o     = count_q;

endmodule

// File: rtl/axil_sram_slave.sv
// rtl/axil_sram_slave.sv - AXI4-Lite SRAM slave with window decode; AXIL_SRAM_ADDR_WRAP_EN aliases the window
module axil_sram_slave
    import axil_sram_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    WORDS      = 1024,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready
);

    localparam int BYTES      = DATA_WIDTH / 8;
    localparam int BYTE_SHIFT = byte_shift(DATA_WIDTH);
    localparam int IDX_W      = $clog2(WORDS);

`ifndef AXIL_SRAM_ADDR_WRAP_EN
    localparam int WIN_SHIFT = BYTE_SHIFT + IDX_W;

    // BASE_ADDR is aligned to the window size, so the offset's high bits must all be zero.
    function automatic logic in_window(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] off;
        off = addr - BASE_ADDR;
        return (addr >= BASE_ADDR) && ((off >> WIN_SHIFT) == '0);
    endfunction
`endif

    logic [DATA_WIDTH-1:0] mem_q [WORDS];

    logic                  aw_full_q;
    logic                  aw_full_d;
    logic [IDX_W-1:0]      aw_idx_q;
    logic                  aw_hit_q;
    logic                  w_full_q;
    logic                  w_full_d;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [BYTES-1:0]      wstrb_q;
    logic                  bvalid_q;
    logic                  bvalid_d;
    logic [1:0]            bresp_q;
    logic [1:0]            bresp_d;

    logic                  aw_hs;
    logic                  w_hs;
    logic                  commit;
    logic                  aw_hit;
    logic                  ar_hit;
    logic                  ar_hs;
    logic [IDX_W-1:0]      ar_idx;
    logic [DATA_WIDTH-1:0] ar_data;
    logic                  rfifo_full;
    logic                  rfifo_empty;
    logic [1:0]            rcnt;
    logic                  unused_sink;

`ifdef AXIL_SRAM_ADDR_WRAP_EN
    assign aw_hit = 1'b1;
    assign ar_hit = 1'b1;
`else
    assign aw_hit = in_window(s_axi_awaddr);
    assign ar_hit = in_window(s_axi_araddr);
`endif

    assign unused_sink = ^{s_axi_awaddr, s_axi_araddr, rfifo_full};

    // Write channel: address and data are decoded and parked until both holds are full.
    assign aw_hs  = s_axi_awvalid && !aw_full_q;
    assign w_hs   = s_axi_wvalid && !w_full_q;
    assign commit = aw_full_q && w_full_q && (!bvalid_q || s_axi_bready);

    always_comb begin
        aw_full_d = aw_full_q;
        w_full_d  = w_full_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        if (aw_hs) begin
            aw_full_d = 1'b1;
        end
        if (w_hs) begin
            w_full_d = 1'b1;
        end
        if (bvalid_q && s_axi_bready) begin
            bvalid_d = 1'b0;
        end
        if (commit) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = aw_hit_q ? RESP_OKAY : RESP_DECERR;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            aw_full_q <= 1'b0;
            aw_idx_q  <= '0;
            aw_hit_q  <= 1'b0;
            w_full_q  <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            aw_full_q <= aw_full_d;
            w_full_q  <= w_full_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            if (aw_hs) begin
                aw_idx_q <= s_axi_awaddr[BYTE_SHIFT +: IDX_W];
                aw_hit_q <= aw_hit;
            end
            if (w_hs) begin
                wdata_q <= s_axi_wdata;
                wstrb_q <= s_axi_wstrb;
            end
        end
    end

    // Memory is never cleared; a commit in the reset cycle is dropped along with its holds.
    always_ff @(posedge clk) begin
        if (!reset && commit && aw_hit_q) begin
            for (int b = 0; b < BYTES; b++) begin
                if (wstrb_q[b]) begin
                    mem_q[aw_idx_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
                end
            end
        end
    end

    // Read channel: the array is sampled on the AR handshake edge, so a same-edge write is not seen.
    assign ar_idx  = s_axi_araddr[BYTE_SHIFT +: IDX_W];
    assign ar_hs   = s_axi_arvalid && s_axi_arready;
    assign ar_data = ar_hit ? mem_q[ar_idx] : '0;

    axil_sram_rfifo #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rfifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (ar_hs),
        .push_data_i (ar_data),
        .push_resp_i (ar_hit ? RESP_OKAY : RESP_DECERR),
        .pop_i       (s_axi_rvalid && s_axi_rready),
        .head_data_o (s_axi_rdata),
        .head_resp_o (s_axi_rresp),
        .full_o      (rfifo_full),
        .empty_o     (rfifo_empty),
        .count_o     (rcnt)
    );

    assign s_axi_awready = !aw_full_q;
    assign s_axi_wready  = !w_full_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = (rcnt < 2'd2);
    assign s_axi_rvalid  = !rfifo_empty;

endmodule

// File: tb/tb_axil_sram_slave.sv
// tb/tb_axil_sram_slave.sv - scoreboard bench for axil_sram_slave
module tb_axil_sram_slave;
    import axil_sram_pkg::*;

    localparam int          DW   = 32;
    localparam int          NW   = 1024;
    localparam int          AW   = 32;
    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam logic [31:0] SPAN = 32'h0000_1000;
`ifdef AXIL_SRAM_ADDR_WRAP_EN
    localparam logic [1:0]  OOR_RESP = RESP_OKAY;
`else
    localparam logic [1:0]  OOR_RESP = RESP_DECERR;
`endif

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } rexp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] s_axi_awaddr = '0;
    logic          s_axi_awvalid = 1'b0;
    logic          s_axi_awready;
    logic [DW-1:0] s_axi_wdata = '0;
    logic [3:0]    s_axi_wstrb = '0;
    logic          s_axi_wvalid = 1'b0;
    logic          s_axi_wready;
    logic [1:0]    s_axi_bresp;
    logic          s_axi_bvalid;
    logic          s_axi_bready = 1'b1;
    logic [AW-1:0] s_axi_araddr = '0;
    logic          s_axi_arvalid = 1'b0;
    logic          s_axi_arready;
    logic [DW-1:0] s_axi_rdata;
    logic [1:0]    s_axi_rresp;
    logic          s_axi_rvalid;
    logic          s_axi_rready = 1'b1;

    int         checks = 0;
    int         failures = 0;
    longint     cycle = 0;
    logic [1:0] exp_b[$];
    rexp_t      exp_r[$];
    longint     r_cyc[$];
    logic       stall_seen = 1'b0;
    logic [31:0] stall_data;
    logic [1:0]  stall_resp;

    axil_sram_slave #(
        .DATA_WIDTH (DW),
        .WORDS      (NW),
        .ADDR_WIDTH (AW),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic report_timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s: handshake not seen within cycle budget", name);
    endtask

    // Monitor: pops the scoreboard on every B/R handshake, checks R holds steady while stalled.
    always @(negedge clk) begin
        if (reset) begin
            stall_seen = 1'b0;
        end else begin
            if (s_axi_bvalid && s_axi_bready) begin
                if (exp_b.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL b_unexpected: got bresp %0h with empty scoreboard", s_axi_bresp);
                end else begin
                    check("bresp", s_axi_bresp, exp_b.pop_front());
                end
            end
            if (s_axi_rvalid) begin
                if (stall_seen) begin
                    check("rdata_stable", {s_axi_rresp, s_axi_rdata}, {stall_resp, stall_data});
                end
                if (s_axi_rready) begin
                    r_cyc.push_back(cycle);
                    stall_seen = 1'b0;
                    if (exp_r.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL r_unexpected: got rdata %0h with empty scoreboard", s_axi_rdata);
                    end else begin
                        rexp_t e;
                        e = exp_r.pop_front();
                        check("rdata", s_axi_rdata, e.data);
                        check("rresp", s_axi_rresp, e.resp);
                    end
                end else begin
                    stall_seen = 1'b1;
                    stall_data = s_axi_rdata;
                    stall_resp = s_axi_rresp;
                end
            end else begin
                stall_seen = 1'b0;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] resp);
        bit aw_done;
        bit w_done;
        aw_done = 1'b0;
        w_done  = 1'b0;
        exp_b.push_back(resp);
        s_axi_awaddr  = addr;
        s_axi_awvalid = 1'b1;
        s_axi_wdata   = data;
        s_axi_wstrb   = strb;
        s_axi_wvalid  = 1'b1;
        for (int i = 0; i < 50 && !(aw_done && w_done); i++) begin
            @(negedge clk);
            if (s_axi_awvalid && s_axi_awready) aw_done = 1'b1;
            if (s_axi_wvalid && s_axi_wready) w_done = 1'b1;
            @(posedge clk);
            #1;
            if (aw_done) s_axi_awvalid = 1'b0;
            if (w_done) s_axi_wvalid = 1'b0;
        end
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        if (!(aw_done && w_done)) report_timeout("write_handshake");
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp);
        bit done;
        rexp_t e;
        done   = 1'b0;
        e.data = data;
        e.resp = resp;
        exp_r.push_back(e);
        s_axi_araddr  = addr;
        s_axi_arvalid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (s_axi_arready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        s_axi_arvalid = 1'b0;
        if (!done) report_timeout("read_handshake");
    endtask

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        @(negedge clk);
        check("rst_awready", s_axi_awready, 1);
        check("rst_wready", s_axi_wready, 1);
        check("rst_arready", s_axi_arready, 1);
        check("rst_bvalid", s_axi_bvalid, 0);
        check("rst_rvalid", s_axi_rvalid, 0);
        check("rst_bresp", s_axi_bresp, 0);
        check("rst_rresp", s_axi_rresp, 0);
        check("rst_rdata", s_axi_rdata, 0);
        @(posedge clk);
        #1;

        // Byte-strobe merge into an existing word.
        do_write(BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, RESP_OKAY);
        do_write(BASE + 32'h10, 32'h0000_00AA, 4'h1, RESP_OKAY);
        idle(3);
        do_read(BASE + 32'h10, 32'hDEAD_BEAA, RESP_OKAY);
        idle(3);

        // W three cycles ahead of AW; bready held low so the B beat is observable.
        s_axi_bready = 1'b0;
        exp_b.push_back(RESP_OKAY);
        s_axi_wdata  = 32'h1234_5678;
        s_axi_wstrb  = 4'hF;
        s_axi_wvalid = 1'b1;
        @(negedge clk);
        check("wearly_wready", s_axi_wready, 1);
        @(posedge clk);
        #1;
        s_axi_wvalid = 1'b0;
        @(negedge clk);
        check("wearly_wready_drop", s_axi_wready, 0);
        check("wearly_no_bvalid", s_axi_bvalid, 0);
        idle(2);
        s_axi_awaddr  = BASE + 32'h4;
        s_axi_awvalid = 1'b1;
        @(negedge clk);
        check("wearly_awready", s_axi_awready, 1);
        @(posedge clk);
        #1;
        s_axi_awvalid = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("wearly_bvalid", s_axi_bvalid, 1);
        check("wearly_bresp", s_axi_bresp, RESP_OKAY);
        @(posedge clk);
        #1;
        s_axi_bready = 1'b1;
        idle(3);
        do_read(BASE + 32'h4, 32'h1234_5678, RESP_OKAY);
        idle(3);

        // B back-pressure: second pair parks in the holds.
        s_axi_bready = 1'b0;
        do_write(BASE + 32'h20, 32'h1111_1111, 4'hF, RESP_OKAY);
        do_write(BASE + SPAN, 32'h2222_2222, 4'hF, OOR_RESP);
        idle(1);
        @(negedge clk);
        check("bp_awready", s_axi_awready, 0);
        check("bp_wready", s_axi_wready, 0);
        check("bp_bvalid", s_axi_bvalid, 1);
        check("bp_bresp_first", s_axi_bresp, RESP_OKAY);
        @(posedge clk);
        #1;
        s_axi_bready = 1'b1;
        idle(4);
        check("bp_b_drained", exp_b.size(), 0);

        // Preload eight words, then eight back-to-back reads.
        for (int i = 0; i < 8; i++) begin
            do_write(BASE + 32'h100 + 32'(i * 4), 32'hA000_0000 + 32'(i), 4'hF, RESP_OKAY);
        end
        idle(3);
        r_cyc.delete();
        for (int i = 0; i < 8; i++) begin
            do_read(BASE + 32'h100 + 32'(i * 4), 32'hA000_0000 + 32'(i), RESP_OKAY);
        end
        idle(4);
        check("b2b_beats", r_cyc.size(), 8);
        if (r_cyc.size() == 8) check("b2b_spacing", r_cyc[7] - r_cyc[0], 7);

        // Same reads with R stalled for four cycles.
        r_cyc.delete();
        s_axi_rready = 1'b0;
        do_read(BASE + 32'h100, 32'hA000_0000, RESP_OKAY);
        do_read(BASE + 32'h104, 32'hA000_0001, RESP_OKAY);
        @(negedge clk);
        check("stall_arready", s_axi_arready, 0);
        check("stall_rvalid", s_axi_rvalid, 1);
        idle(2);
        s_axi_rready = 1'b1;
        for (int i = 2; i < 8; i++) begin
            do_read(BASE + 32'h100 + 32'(i * 4), 32'hA000_0000 + 32'(i), RESP_OKAY);
        end
        idle(5);
        check("stall_beats", r_cyc.size(), 8);
        check("stall_r_drained", exp_r.size(), 0);

        // One word past the window.
        do_write(BASE, 32'h0BAD_F00D, 4'hF, RESP_OKAY);
        idle(2);
        do_write(BASE + SPAN, 32'h55AA_55AA, 4'hF, OOR_RESP);
        idle(3);
`ifdef AXIL_SRAM_ADDR_WRAP_EN
        do_read(BASE + SPAN, 32'h55AA_55AA, RESP_OKAY);
        do_read(BASE, 32'h55AA_55AA, RESP_OKAY);
`else
        do_read(BASE + SPAN, 32'h0, RESP_DECERR);
        do_read(BASE, 32'h0BAD_F00D, RESP_OKAY);
        do_read(BASE - 32'h4, 32'h0, RESP_DECERR);
`endif
        idle(4);

        // Reset with a queued read beat and a pending B response.
        s_axi_rready = 1'b0;
        s_axi_bready = 1'b0;
        do_read(BASE + 32'h10, 32'hDEAD_BEAA, RESP_OKAY);
        do_write(BASE + 32'h30, 32'h3333_3333, 4'hF, RESP_OKAY);
        idle(1);
        @(negedge clk);
        check("pre_rst_bvalid", s_axi_bvalid, 1);
        check("pre_rst_rvalid", s_axi_rvalid, 1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_b.delete();
        exp_r.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_bvalid", s_axi_bvalid, 0);
        check("post_rst_rvalid", s_axi_rvalid, 0);
        check("post_rst_awready", s_axi_awready, 1);
        check("post_rst_wready", s_axi_wready, 1);
        check("post_rst_arready", s_axi_arready, 1);
        @(posedge clk);
        #1;
        s_axi_rready = 1'b1;
        s_axi_bready = 1'b1;
        do_read(BASE + 32'h10, 32'hDEAD_BEAA, RESP_OKAY);
        idle(4);

        check("final_b_empty", exp_b.size(), 0);
        check("final_r_empty", exp_r.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
